zombie_row_scan_ctrl: RTL
=========================

Name: zombie_row_scan_ctrl

Overview:
Per-frame scheduler that builds the per-row pea stop positions by scanning the zombie slot table one slot per clock. It replaces a wide 10-way combinational compare with a small sequential scan. It sits between the zombie slot registers, which are read through an indexed read port, and the pea movers, which consume stopX1..stopX5. Results publish atomically once per frame with a done pulse.

Parameters:
N_ZOM, 10, number of zombie slots scanned (index width = $clog2(N_ZOM))
ROW0_Y, 110, central Y of lawn row 1
ROW_PITCH, 70, Y spacing between rows; row k (k=0..4) has Y = ROW0_Y + k*ROW_PITCH
EMPTY_X, 1023, stop value published for a row with no live zombie

Ports:
MAX10_CLK1_50  in   1   system clock, all logic on rising edge
Reset_n        in   1   synchronous active-low reset
frame_start    in   1   one-cycle pulse per frame (vsync edge); requests a scan
zom_idx        out  $clog2(N_ZOM)  slot index being read
zom_x          in   10  central X of slot zom_idx (combinational, same cycle)
zom_y          in   10  central Y of slot zom_idx
zom_live       in   1   slot zom_idx is alive
stopX1..stopX5 out  10 each  published leftmost live-zombie X for rows 1..5
done           out  1   one-cycle pulse: stopX* updated this cycle
busy           out  1   high in SCAN or PUBLISH
overrun        out  1   one-cycle pulse: frame_start dropped because busy

Behaviour:
- Reset (Reset_n=0 at edge): state=IDLE, zom_idx=0, working mins=EMPTY_X, stopX1..5=EMPTY_X, done=0, overrun=0. Reset mid-scan aborts the scan; published values return to EMPTY_X.
- FSM states: IDLE, SCAN, PUBLISH.
- IDLE: zom_idx=0. If frame_start=1 at edge: load all 5 working mins to EMPTY_X, idx=0, go to SCAN.
- SCAN: zom_idx=idx. At each edge, sample zom_*. If zom_live and zom_y equals exactly row k's Y and zom_x < work[k] (strict), then work[k]<=zom_x. A Y matching no row is ignored; a dead slot is ignored. Ties keep the earlier value. If idx==N_ZOM-1, go to PUBLISH, else idx<=idx+1. Exactly N_ZOM SCAN cycles.
- PUBLISH: at the edge, stopXk<=work[k-1] for all rows simultaneously, done<=1 for one cycle, go to IDLE.
- Latency: with frame_start sampled at edge E0, SCAN spans edges E1..E10 and PUBLISH ends at E11. New stopX* and done=1 are visible after E11 (N_ZOM+2 edges). Between publishes, stopX* hold their previous values; consumers never see a partial scan.
- frame_start while busy (SCAN or PUBLISH): ignored; overrun<=1 for one cycle. The scan in progress is unaffected. A frame_start in the IDLE cycle right after PUBLISH starts a new scan normally.
- busy is combinational from the state; done and overrun are registered.
- Width rules: all compares are 10-bit unsigned. A live zombie at X=1023 is indistinguishable from an empty row (accepted).
- Row Y constants are computed at elaboration; no multiply in hardware.

Decomposition:
- Shared package (game_pkg): N_ROWS=5, coordinate width 10, ROW0_Y/ROW_PITCH lawn constants, EMPTY_X, and the scan state enum typedef. These are shared with the pea, zombie and plant blocks.
- One sub-module: row_match, which is combinational. It maps zom_y to a one-hot 5-bit row select (zero if no match). The update datapath is 5 instances of compare-and-load inside the top.
- The zombie slot table keeps the read mux (zom_idx -> zom_*); it is not in this block.

Test Plan:
- Reset then idle: Reset_n=0 for 2 cycles, release, no frame_start -> stopX1..5=1023, done=0, busy=0 indefinitely.
- Single zombie: only slot 3 live at (400,180), frame_start -> done exactly 12 edges later; stopX2=400, others=1023; zom_idx swept 0..9.
- Min and tie: slots 0,5,9 live in row 1 at X=300,250,250, plus slot 2 dead at X=10 in row 1 -> stopX1=250, dead slot ignored.
- Off-row/all rows: one live zombie per row at Y=110,180,250,320,390 with X=500,400,300,200,100, and slot 7 live at Y=111 -> stopX1..5=500,400,300,200,100; Y=111 ignored.
- Overrun: second frame_start 4 cycles into SCAN -> overrun pulses once, done pulses once at the original time, no second scan. A frame_start 1 cycle after done starts a new scan.
- Reset mid-scan: publish non-empty values, start a scan, assert Reset_n=0 at SCAN idx=5 -> next cycle state IDLE, stopX*=1023, no done pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Lawn-wide constants and types shared by the pea, zombie, plant and scan blocks.
package game_pkg;

    localparam int N_ROWS    = 5;
    localparam int COORD_W   = 10;
    localparam int ROW0_Y    = 110;
    localparam int ROW_PITCH = 70;
    localparam int EMPTY_X   = 1023;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PUBLISH = 2'd2
    } scan_state_t;

    // Evaluated at elaboration only, so no multiplier reaches hardware.
    function automatic logic [COORD_W-1:0] row_y(input int k, input int row0, input int pitch);
        return COORD_W'(row0 + k * pitch);
    endfunction

endpackage

// File: rtl/zombie_row_scan_ctrl_row_match.sv
// Maps a zombie Y coordinate to a one-hot lawn row select; all zero when Y is off-row.
module row_match
    import game_pkg::*;
#(
    parameter int ROW0_Y    = game_pkg::ROW0_Y,
    parameter int ROW_PITCH = game_pkg::ROW_PITCH
) (
    input  logic [COORD_W-1:0] y,
    output logic [N_ROWS-1:0]  sel
);

    for (genvar k = 0; k < N_ROWS; k++) begin : g_row
        localparam logic [COORD_W-1:0] ROW_Y = row_y(k, ROW0_Y, ROW_PITCH);
        assign sel[k] = (y == ROW_Y);
    end

endmodule

// File: rtl/zombie_row_scan_ctrl.sv
// Per-frame scan of the zombie slot table, one slot per clock, building the leftmost
// live-zombie X for each lawn row and publishing all five rows atomically.
module zombie_row_scan_ctrl
    import game_pkg::*;
#(
    parameter int N_ZOM     = 10,
    parameter int ROW0_Y    = game_pkg::ROW0_Y,
    parameter int ROW_PITCH = game_pkg::ROW_PITCH,
    parameter int EMPTY_X   = game_pkg::EMPTY_X
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    output logic [$clog2(N_ZOM)-1:0] zom_idx,
    input  logic [COORD_W-1:0]       zom_x,
    input  logic [COORD_W-1:0]       zom_y,
    input  logic                     zom_live,
    output logic [COORD_W-1:0]       stopX1,
    output logic [COORD_W-1:0]       stopX2,
    output logic [COORD_W-1:0]       stopX3,
    output logic [COORD_W-1:0]       stopX4,
    output logic [COORD_W-1:0]       stopX5,
    output logic                     done,
    output logic                     busy,
    output logic                     overrun
);

    localparam int IDX_W = $clog2(N_ZOM);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_ZOM - 1);
    localparam logic [COORD_W-1:0] EMPTY    = COORD_W'(EMPTY_X);

    scan_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [COORD_W-1:0]   work_q [N_ROWS];
    logic [COORD_W-1:0]   stop_q [N_ROWS];
    logic [N_ROWS-1:0]    row_sel;
    logic                 done_q;
    logic                 overrun_q;
    logic                 start_scan;
    logic                 last_slot;

    row_match #(
        .ROW0_Y    (ROW0_Y),
        .ROW_PITCH (ROW_PITCH)
    ) u_row_match (
        .y   (zom_y),
        .sel (row_sel)
    );

    assign start_scan = (state_q == ST_IDLE) && frame_start;
    assign last_slot  = (idx_q == IDX_LAST);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_SCAN;
            ST_SCAN:    if (last_slot) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!Reset_n) begin
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= (state_q == ST_PUBLISH);
            overrun_q <= frame_start && busy;
            if (state_q == ST_SCAN && !last_slot) begin
                idx_q <= idx_q + IDX_W'(1);
            end else begin
                idx_q <= '0;
            end
        end
    end

    // One compare-and-load per row; strict less-than so ties keep the earlier slot.
    for (genvar k = 0; k < N_ROWS; k++) begin : g_row
        always_ff @(posedge MAX10_CLK1_50) begin
            if (!Reset_n) begin
                work_q[k] <= EMPTY;
                stop_q[k] <= EMPTY;
            end else begin
                if (start_scan) begin
                    work_q[k] <= EMPTY;
                end else if (state_q == ST_SCAN && zom_live && row_sel[k] && (zom_x < work_q[k])) begin
                    work_q[k] <= zom_x;
                end
                if (state_q == ST_PUBLISH) begin
                    stop_q[k] <= work_q[k];
                end
            end
        end
    end

    assign zom_idx = (state_q == ST_SCAN) ? idx_q : '0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign overrun = overrun_q;
    assign stopX1  = stop_q[0];
    assign stopX2  = stop_q[1];
    assign stopX3  = stop_q[2];
    assign stopX4  = stop_q[3];
    assign stopX5  = stop_q[4];

endmodule
